// File: rtl/shift_sub_divider_if.sv
// Handshake and result bundle of the shift-and-subtract divider.
// The master issues divisions and the slave (the divider) returns results.
interface shift_sub_divider_if #(
  parameter int unsigned WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] input1;
  logic [WIDTH-1:0] input2;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  modport master (
    output start, input1, input2,
    input  quotient, remainder, busy, done, div_by_zero
  );

  modport slave (
    input  start, input1, input2,
    output quotient, remainder, busy, done, div_by_zero
  );
endinterface

// File: rtl/shift_sub_divider.sv
// Sequential 16-bit unsigned restoring divider: one quotient bit per clock,
// results and a one-cycle done pulse after 16 iterations.
module shift_sub_divider (
  input  logic               clk,
  input  logic               rst_n,
  shift_sub_divider_if.slave bus
);
  localparam int unsigned WIDTH = 16;
  localparam int unsigned CNT_W = $clog2(WIDTH);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] d_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] r_reg;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH:0]   t;
  logic             ge;
  logic [WIDTH-1:0] r_next;
  logic [WIDTH-1:0] q_next;

  // One restoring step; the trial value is WIDTH+1 bits so a full-scale
  // divisor never overflows the compare or subtract.
  always_comb begin
    t      = {r_reg, q_reg[WIDTH-1]};
    ge     = (t >= {1'b0, d_reg});
    r_next = ge ? WIDTH'(t - {1'b0, d_reg}) : t[WIDTH-1:0];
    q_next = {q_reg[WIDTH-2:0], ge};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      d_reg           <= '0;
      q_reg           <= '0;
      r_reg           <= '0;
      cnt             <= '0;
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.div_by_zero <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.input2 == '0) begin
              // Divide by zero resolves immediately without iterating.
              bus.quotient    <= '1;
              bus.remainder   <= bus.input1;
              bus.div_by_zero <= 1'b1;
              bus.done        <= 1'b1;
            end else begin
              d_reg    <= bus.input2;
              q_reg    <= bus.input1;
              r_reg    <= '0;
              cnt      <= '0;
              bus.busy <= 1'b1;
              state    <= CALC;
            end
          end
        end
        CALC: begin
          q_reg <= q_next;
          r_reg <= r_next;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) begin
            bus.quotient    <= q_next;
            bus.remainder   <= r_next;
            bus.div_by_zero <= 1'b0;
            bus.done        <= 1'b1;
            bus.busy        <= 1'b0;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_shift_sub_divider.sv
// Scoreboard bench for shift_sub_divider: expectations are queued at issue
// time and compared when done pulses; latency and busy are checked inline.
module tb_shift_sub_divider;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  shift_sub_divider_if #(.WIDTH(16)) bus ();

  shift_sub_divider dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        dz;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    if (b == 16'd0) begin
      e.q  = 16'hFFFF;
      e.r  = a;
      e.dz = 1'b1;
    end else begin
      e.q  = a / b;
      e.r  = a % b;
      e.dz = 1'b0;
    end
    return e;
  endfunction

  // Result monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("quotient", 32'(bus.quotient), 32'(e.q));
        check("remainder", 32'(bus.remainder), 32'(e.r));
        check("div_by_zero", 32'(bus.div_by_zero), 32'(e.dz));
      end
    end
  end

  task automatic start_op(input logic [15:0] a, input logic [15:0] b, input bit hold);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.input1 = a;
    bus.input2 = b;
    sb.push_back(model(a, b));
    @(posedge clk);
    #1;
    if (!hold) bus.start = 1'b0;
  endtask

  // Called one step after the accepting edge; counts edges until done.
  task automatic wait_done(input string tag, output int lat, output int busy_cyc);
    lat      = 0;
    busy_cyc = 0;
    while (bus.done !== 1'b1 && lat < 40) begin
      if (bus.busy === 1'b1) busy_cyc++;
      @(posedge clk);
      #1;
      lat++;
    end
    if (bus.done !== 1'b1) check({tag, "_timeout"}, 32'd0, 32'd1);
    else check({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
  endtask

  logic [15:0] dir_a [5] = '{16'd65535, 16'd1000, 16'd0, 16'd100, 16'd50};
  logic [15:0] dir_b [5] = '{16'd1, 16'd1209, 16'd7, 16'd0, 16'd7};

  initial begin
    int lat, bc, m;
    logic [15:0] a, b;

    // Reset with start already high: the first edge after release accepts it.
    bus.start  = 1'b1;
    bus.input1 = 16'd1209;
    bus.input2 = 16'd1000;
    #12;
    check("rst_quotient", 32'(bus.quotient), 32'd0);
    check("rst_remainder", 32'(bus.remainder), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_dz", 32'(bus.div_by_zero), 32'd0);
    sb.push_back(model(16'd1209, 16'd1000));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done("div1209", lat, bc);
    check("div1209_latency", 32'(lat), 32'd16);
    check("div1209_busy_cycles", 32'(bc), 32'd16);
    @(posedge clk);
    #1;
    check("done_width", 32'(bus.done), 32'd0);

    // Directed corner operands, including divide by zero then recovery.
    for (int i = 0; i < 5; i++) begin
      start_op(dir_a[i], dir_b[i], 1'b0);
      wait_done("directed", lat, bc);
      check("directed_latency", 32'(lat), (dir_b[i] == 16'd0) ? 32'd0 : 32'd16);
      check("directed_busy_cycles", 32'(bc), (dir_b[i] == 16'd0) ? 32'd0 : 32'd16);
    end

    // Back-to-back with start held high; input changes while busy are ignored.
    start_op(16'd40000, 16'd3, 1'b1);
    bus.input1 = 16'd65535;
    bus.input2 = 16'd65535;
    sb.push_back(model(16'd65535, 16'd65535));
    wait_done("b2b_first", lat, bc);
    check("b2b_first_latency", 32'(lat), 32'd16);
    m = 0;
    do begin
      @(posedge clk);
      #1;
      m++;
      if (m == 1) bus.start = 1'b0;
    end while (bus.done !== 1'b1 && m < 40);
    check("b2b_gap", 32'(m), 32'd17);

    // Asynchronous reset in the middle of an iteration: no done must follow.
    @(negedge clk);
    bus.start  = 1'b1;
    bus.input1 = 16'd1209;
    bus.input2 = 16'd1000;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_quotient", 32'(bus.quotient), 32'd0);
    check("abort_remainder", 32'(bus.remainder), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_dz", 32'(bus.div_by_zero), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    start_op(16'd1209, 16'd1000, 1'b0);
    wait_done("after_reset", lat, bc);
    check("after_reset_latency", 32'(lat), 32'd16);

    // Random sweep with forced full-scale and zero-divisor cases.
    for (int i = 0; i < 1000; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      if (i == 0) b = 16'hFFFF;
      else if (i == 1) a = 16'hFFFF;
      else if (i == 2) begin a = 16'hFFFF; b = 16'hFFFF; end
      else if (i % 50 == 7) b = 16'd0;
      else if (i % 3 == 0) b = 16'($urandom_range(1, 300));
      start_op(a, b, 1'b0);
      wait_done("random", lat, bc);
    end

    repeat (3) @(posedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/shift_sub_divider.md
# shift_sub_divider

Sequential 16-bit unsigned restoring divider: the shift-and-subtract counterpart to the team's 16-bit shift-and-add arithmetic block. It accepts a dividend/divisor pair on a start pulse, iterates one quotient bit per clock, and returns quotient and remainder with a one-cycle done pulse. It sits beside the adder/multiplier datapath as the inverse arithmetic unit.

## Interface
- WIDTH, 16, operand/result width; all values below assume 16.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only when busy=0.
- input1  in  16  dividend, unsigned; sampled on the accepting edge.
- input2  in  16  divisor, unsigned; sampled on the accepting edge.
- quotient  out  16  result quotient; held until the next completion.
- remainder  out  16  result remainder; held until the next completion.
- busy  out  1  high while a division is in progress.
- done  out  1  single-cycle pulse when quotient/remainder update.
- div_by_zero  out  1  status of the last completed operation; held with results.

## Operation
- Reset (rst_n=0, asynchronous): state=IDLE; quotient, remainder, busy, done, div_by_zero, iteration counter and internal registers all 0.
- States: IDLE, CALC. No other states.
- IDLE with start=1 and input2!=0: latch D=input2, Q=input1, R=0 (17 bits), counter=0; go to CALC; busy=1.
- IDLE with start=1 and input2=0: stay in IDLE; on the same edge set quotient=16'hFFFF, remainder=input1, div_by_zero=1, done=1 for one cycle. Do not enter CALC.
- CALC, each edge: T={R[15:0], Q[15]}; if T>=D then R=T-D and the shifted-in quotient bit is 1, else R=T and the shifted-in bit is 0; Q={Q[14:0], bit}; counter+1.
- Compare and subtract use 17-bit width, so there is no overflow for any divisor up to 16'hFFFF.
- On the 16th CALC edge (counter=15): quotient=final Q, remainder=final R[15:0], div_by_zero=0, done=1, busy=0; return to IDLE.
- start while busy=1 is ignored, with no queueing. input1/input2 changes during CALC have no effect.
- Outputs change only on completion edges or on reset. Between completions they hold their last values.

## Timing
- Normal latency: start sampled at edge E0; done high during the cycle after edge E16; busy high from after E0 until after E16 (16 cycles).
- Divide-by-zero latency: done high during the cycle after E0; busy stays 0.
- done is exactly one cycle wide, and busy=0 during that cycle.
- Back-to-back: start=1 in the done cycle is accepted on the next edge. Throughput is 17 cycles per division.
- Reset mid-CALC: all outputs go to 0 immediately (asynchronously). No done is produced for the aborted operation. A start after reset release behaves normally.
- Reset deasserted with start=1 on the first edge: that start is accepted.

## Test plan
- 1209 / 1000, start one cycle -> done exactly 16 cycles after the accepting edge; quotient=1, remainder=209, div_by_zero=0, busy high for 16 cycles.
- 65535 / 1 -> quotient=65535, remainder=0. Also 1000 / 1209 -> quotient=0, remainder=1000. Also 0 / 7 -> quotient=0, remainder=0.
- 100 / 0 -> done one cycle after the accepting edge; quotient=16'hFFFF, remainder=100, div_by_zero=1, busy never high. The next valid divide (50 / 7) clears div_by_zero and gives quotient=7, remainder=1.
- Back-to-back: 40000 / 3 then 65535 / 65535, with start held high through the done cycle -> results 13333 r 1, then 1 r 0. The second done is 17 cycles after the first. start pulses during busy are ignored.
- Reset asserted at CALC iteration 8 of 1209 / 1000 -> all outputs 0 immediately and no done pulse. After release, 1209 / 1000 completes with 1 r 209.
- Random sweep of 1000 operand pairs, including divisor 16'hFFFF and dividend 16'hFFFF -> quotient*divisor+remainder == dividend and remainder < divisor for every nonzero divisor.
